// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath/memory.
// master: sequencer side (IR fields, ALU zero and mem_ready in; enables/selects out).
// slave:  datapath/memory side (the mirror image).
interface mc_ctrl_if;
    // Instruction fields and status from the datapath / memory
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    // Memory port controls
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    // Datapath enables and mux selects
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] reg_data;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    // Status
    logic       instr_done;
    logic       bus_err;
    logic [2:0] state;

    modport master (
        input  op, func, zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, reg_dst, reg_data, alu_src, alu_op, ext_op,
               instr_done, bus_err, state
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, reg_dst, reg_data, alu_src, alu_op, ext_op,
               instr_done, bus_err, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Latency: j/jal/jr/nop 2, beq 3, sw/R/ori/lui 4, lw 5 cycles, +1 per mem_ready-low cycle.
// Backpressure: mem_req held stable until mem_ready; TIMEOUT wait cycles -> sticky bus_err, HALT.
// Ports: clk, reset (sync, active-low), bus (mc_ctrl_if.master: IR fields/zero/mem_ready in,
//        memory controls, datapath enables/selects, instr_done, bus_err, state out).
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    mc_ctrl_if.master    bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;

    // Instruction decode from the IR fields
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic to_exec;
    logic       alu_src_dec, ext_op_dec;
    logic [2:0] alu_op_dec;

    assign is_r    = (bus.op == 6'h00);
    assign is_addu = is_r && (bus.func == 6'h21);
    assign is_subu = is_r && (bus.func == 6'h23);
    assign is_jr   = is_r && (bus.func == 6'h08);
    assign is_ori  = (bus.op == 6'h0d);
    assign is_lui  = (bus.op == 6'h0f);
    assign is_lw   = (bus.op == 6'h23);
    assign is_sw   = (bus.op == 6'h2b);
    assign is_beq  = (bus.op == 6'h04);
    assign is_j    = (bus.op == 6'h02);
    assign is_jal  = (bus.op == 6'h03);
    assign to_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

    assign alu_src_dec = is_ori | is_lui | is_lw | is_sw;
    assign ext_op_dec  = is_lw | is_sw;
    assign alu_op_dec  = is_lui            ? 3'd3 :
                         is_ori            ? 3'd2 :
                         (is_subu | is_beq) ? 3'd1 : 3'd0;

    // Ungated control values; all are forced low while reset is held
    logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_write_c, pc_write_c;
    logic [1:0] pc_src_c;
    logic       reg_write_c;
    logic [1:0] reg_dst_c, reg_data_c;
    logic       alu_src_c;
    logic [2:0] alu_op_c;
    logic       ext_op_c, instr_done_c;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_err_d      = bus_err_q;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        pc_src_c       = 2'd0;
        reg_write_c    = 1'b0;
        reg_dst_c      = 2'd0;
        reg_data_c     = 2'd0;
        alu_src_c      = 1'b0;
        alu_op_c       = 3'd0;
        ext_op_c       = 1'b0;
        instr_done_c   = 1'b0;

        // ALU controls follow the decoded instruction through EXEC, MEM and WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_src_c = alu_src_dec;
            ext_op_c  = ext_op_dec;
            alu_op_c  = alu_op_dec;
        end

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_write_c   = 1'b1;
                    pc_src_c     = 2'd2;
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                    if (is_jal) begin
                        reg_write_c = 1'b1;
                        reg_dst_c   = 2'd2;
                        reg_data_c  = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_write_c   = 1'b1;
                    pc_src_c     = 2'd3;
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end else if (to_exec) begin
                    state_d = S_EXEC;
                end else begin
                    // Unsupported encoding retires as a nop
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_write_c   = bus.zero;
                    pc_src_c     = 2'd1;
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = is_sw;
                if (bus.mem_ready) begin
                    if (is_sw) begin
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = (is_lw | is_ori | is_lui) ? 2'd1 : 2'd0;
                reg_data_c   = is_lw ? 2'd1 : 2'd0;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Watchdog: count unanswered request cycles. The cycle that would bring
        // the count to TIMEOUT without mem_ready trips the error; a mem_ready on
        // that same cycle wins and the transfer completes normally.
        if (mem_req_c && !bus.mem_ready) begin
            if (cnt_q >= (TO_LIM - 8'd1)) begin
                cnt_d     = TO_LIM;
                bus_err_d = 1'b1;
                state_d   = S_HALT;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.mem_req      = reset & mem_req_c;
    assign bus.mem_we       = reset & mem_we_c;
    assign bus.mem_addr_sel = reset & mem_addr_sel_c;
    assign bus.ir_write     = reset & ir_write_c;
    assign bus.pc_write     = reset & pc_write_c;
    assign bus.pc_src       = reset ? pc_src_c   : 2'd0;
    assign bus.reg_write    = reset & reg_write_c;
    assign bus.reg_dst      = reset ? reg_dst_c  : 2'd0;
    assign bus.reg_data     = reset ? reg_data_c : 2'd0;
    assign bus.alu_src      = reset & alu_src_c;
    assign bus.alu_op       = reset ? alu_op_c   : 3'd0;
    assign bus.ext_op       = reset & ext_op_c;
    assign bus.instr_done   = reset & instr_done_c;
    assign bus.bus_err      = reset & bus_err_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed vector table, hand sequences for reset/wait/timeout,
// and randomized instruction streams checked against a per-instruction phase model.
module tb_mc_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst, reg_data;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       ext_op, instr_done, bus_err;
    } outv_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op, fn;
        logic       z, rdy;
        outv_t      e;
    } vec_t;

    typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_NOP} cls_t;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

    function automatic outv_t ev(int st, bit mr, bit mw, bit mas, bit irw, bit pcw, int psrc,
                                 bit rw, int dst, int dat, bit as, int aop, bit ext, bit dn, bit be);
        outv_t o;
        o.state = 3'(st); o.mem_req = mr; o.mem_we = mw; o.mem_addr_sel = mas;
        o.ir_write = irw; o.pc_write = pcw; o.pc_src = 2'(psrc); o.reg_write = rw;
        o.reg_dst = 2'(dst); o.reg_data = 2'(dat); o.alu_src = as; o.alu_op = 3'(aop);
        o.ext_op = ext; o.instr_done = dn; o.bus_err = be;
        return o;
    endfunction

    function automatic outv_t sample();
        outv_t o;
        o.state = bus.state; o.mem_req = bus.mem_req; o.mem_we = bus.mem_we;
        o.mem_addr_sel = bus.mem_addr_sel; o.ir_write = bus.ir_write; o.pc_write = bus.pc_write;
        o.pc_src = bus.pc_src; o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;
        o.reg_data = bus.reg_data; o.alu_src = bus.alu_src; o.alu_op = bus.alu_op;
        o.ext_op = bus.ext_op; o.instr_done = bus.instr_done; o.bus_err = bus.bus_err;
        return o;
    endfunction

    // Drive one cycle's inputs (caller is just past a posedge), check at negedge.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input outv_t e, input string nm);
        outv_t act;
        reset = r; bus.op = op; bus.func = fn; bus.zero = z; bus.mem_ready = rdy;
        @(negedge clk);
        act = sample();
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h (state got %0d want %0d)",
                     nm, $time, act, e, act.state, e.state);
        end
        @(posedge clk); #1;
    endtask

    task automatic tick(input logic r);
        reset = r; bus.op = 6'($urandom); bus.func = 6'($urandom);
        bus.zero = 1'($urandom); bus.mem_ready = 1'($urandom);
        @(posedge clk); #1;
    endtask

    function automatic void enc(input cls_t c, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (c)
            C_ADDU: begin op = 6'h00; fn = 6'h21; end
            C_SUBU: begin op = 6'h00; fn = 6'h23; end
            C_JR:   begin op = 6'h00; fn = 6'h08; end
            C_ORI:  op = 6'h0d;
            C_LUI:  op = 6'h0f;
            C_LW:   op = 6'h23;
            C_SW:   op = 6'h2b;
            C_BEQ:  op = 6'h04;
            C_J:    op = 6'h02;
            C_JAL:  op = 6'h03;
            default: begin
                case ($urandom_range(0, 3))
                    0: op = 6'h3f;
                    1: begin op = 6'h00; fn = 6'h20; end
                    2: op = 6'h08;
                    default: begin op = 6'h00; fn = 6'h00; end
                endcase
            end
        endcase
    endfunction

    // Expected controls for one cycle of an instruction class in a given phase.
    function automatic outv_t exp_out(int ph, cls_t c, bit acc, bit z);
        outv_t o = '0;
        o.state = 3'(ph);
        case (ph)
            P_F: begin o.mem_req = 1; o.ir_write = acc; o.pc_write = acc; end
            P_D: begin
                if (c == C_J || c == C_JAL) begin o.pc_write = 1; o.pc_src = 2; o.instr_done = 1; end
                if (c == C_JAL) begin o.reg_write = 1; o.reg_dst = 2; o.reg_data = 2; end
                if (c == C_JR) begin o.pc_write = 1; o.pc_src = 3; o.instr_done = 1; end
                if (c == C_NOP) o.instr_done = 1;
            end
            P_E: if (c == C_BEQ) begin o.pc_write = z; o.pc_src = 1; o.instr_done = 1; end
            P_M: begin
                o.mem_req = 1; o.mem_addr_sel = 1; o.mem_we = (c == C_SW);
                o.instr_done = acc && (c == C_SW);
            end
            P_W: begin
                o.reg_write = 1; o.instr_done = 1;
                o.reg_dst = (c inside {C_LW, C_ORI, C_LUI}) ? 2'd1 : 2'd0;
                o.reg_data = (c == C_LW) ? 2'd1 : 2'd0;
            end
            default: o.bus_err = 1;
        endcase
        if (ph == P_E || ph == P_M || ph == P_W) begin
            o.alu_src = c inside {C_ORI, C_LUI, C_LW, C_SW};
            o.ext_op  = c inside {C_LW, C_SW};
            o.alu_op  = (c == C_LUI) ? 3'd3 : (c == C_ORI) ? 3'd2 :
                        (c == C_SUBU || c == C_BEQ) ? 3'd1 : 3'd0;
        end
        return o;
    endfunction

    // A memory phase answered after w wait cycles; w >= TO never gets answered.
    task automatic mem_wait(input int ph, input cls_t c, input int w, input logic [5:0] op,
                            input logic [5:0] fn, input bit garbage, output bit halted);
        for (int i = 0; i <= w && i < TO; i++) begin
            bit acc = (i == w);
            bit z = 1'($urandom);
            cyc(1'b1, garbage ? 6'($urandom) : op, garbage ? 6'($urandom) : fn, z, acc,
                exp_out(ph, c, acc, z), ph == P_F ? "fetch" : "mem");
        end
        halted = (w >= TO);
    endtask

    task automatic simple_phase(input int ph, input cls_t c, input logic [5:0] op, input logic [5:0] fn);
        bit z = 1'($urandom);
        bit r = 1'($urandom);
        cyc(1'b1, op, fn, z, r, exp_out(ph, c, 1'b0, z),
            ph == P_D ? "decode" : ph == P_E ? "exec" : "wb");
    endtask

    task automatic run_instr(input cls_t c, input int wf, input int wm, output bit halted);
        logic [5:0] op, fn;
        enc(c, op, fn);
        mem_wait(P_F, c, wf, op, fn, 1'b1, halted);
        if (!halted) begin
            simple_phase(P_D, c, op, fn);
            if (c inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ})
                simple_phase(P_E, c, op, fn);
            if (c inside {C_LW, C_SW})
                mem_wait(P_M, c, wm, op, fn, 1'b0, halted);
            if (!halted && c inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW})
                simple_phase(P_W, c, op, fn);
        end
    endtask

    task automatic do_reset(input int n);
        tick(1'b0);
        for (int i = 1; i < n; i++)
            cyc(1'b0, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), '0, "reset hold");
    endtask

    task automatic halt_and_reset();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                exp_out(P_H, C_NOP, 1'b0, 1'b0), "halt");
        do_reset(2);
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 11) == 0) return $urandom_range(TO, TO + 2);
        return $urandom_range(0, TO - 1);
    endfunction

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tv[$];
        outv_t f_ok, f_wait, dec0;
        logic [5:0] op, fn;
        bit h;

        f_ok   = ev(0, 1,0,0, 1,1,0, 0,0,0, 0,0,0, 0,0);
        f_wait = ev(0, 1,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);
        dec0   = ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);

        tv.push_back('{1'b0, 6'h00, 6'h00, 1'b0, 1'b1, ev(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0)});
        // addu
        tv.push_back('{1'b1, 6'h00, 6'h21, 1'b0, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h00, 6'h21, 1'b0, 1'b1, dec0});
        tv.push_back('{1'b1, 6'h00, 6'h21, 1'b1, 1'b1, ev(2, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0)});
        tv.push_back('{1'b1, 6'h00, 6'h21, 1'b0, 1'b1, ev(4, 0,0,0, 0,0,0, 1,0,0, 0,0,0, 1,0)});
        // jal
        tv.push_back('{1'b1, 6'h03, 6'h00, 1'b0, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h03, 6'h00, 1'b0, 1'b1, ev(1, 0,0,0, 0,1,2, 1,2,2, 0,0,0, 1,0)});
        // beq taken / not taken
        tv.push_back('{1'b1, 6'h04, 6'h00, 1'b1, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h04, 6'h00, 1'b1, 1'b1, dec0});
        tv.push_back('{1'b1, 6'h04, 6'h00, 1'b1, 1'b1, ev(2, 0,0,0, 0,1,1, 0,0,0, 0,1,0, 1,0)});
        tv.push_back('{1'b1, 6'h04, 6'h00, 1'b0, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h04, 6'h00, 1'b0, 1'b1, dec0});
        tv.push_back('{1'b1, 6'h04, 6'h00, 1'b0, 1'b1, ev(2, 0,0,0, 0,0,1, 0,0,0, 0,1,0, 1,0)});
        // unknown op 0x3f
        tv.push_back('{1'b1, 6'h3f, 6'h00, 1'b0, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h3f, 6'h00, 1'b0, 1'b1, ev(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0)});
        // ori
        tv.push_back('{1'b1, 6'h0d, 6'h00, 1'b0, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h0d, 6'h00, 1'b0, 1'b1, dec0});
        tv.push_back('{1'b1, 6'h0d, 6'h00, 1'b0, 1'b1, ev(2, 0,0,0, 0,0,0, 0,0,0, 1,2,0, 0,0)});
        tv.push_back('{1'b1, 6'h0d, 6'h00, 1'b0, 1'b1, ev(4, 0,0,0, 0,0,0, 1,1,0, 1,2,0, 1,0)});
        // sw with one fetch wait
        tv.push_back('{1'b1, 6'h2b, 6'h00, 1'b0, 1'b0, f_wait});
        tv.push_back('{1'b1, 6'h2b, 6'h00, 1'b0, 1'b1, f_ok});
        tv.push_back('{1'b1, 6'h2b, 6'h00, 1'b0, 1'b1, dec0});
        tv.push_back('{1'b1, 6'h2b, 6'h00, 1'b0, 1'b1, ev(2, 0,0,0, 0,0,0, 0,0,0, 1,0,1, 0,0)});
        tv.push_back('{1'b1, 6'h2b, 6'h00, 1'b0, 1'b1, ev(3, 1,1,1, 0,0,0, 0,0,0, 1,0,1, 1,0)});
        tv.push_back('{1'b1, 6'h00, 6'h00, 1'b0, 1'b0, f_wait});

        reset = 1'b0; bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        foreach (tv[i])
            cyc(tv[i].rst_n, tv[i].op, tv[i].fn, tv[i].z, tv[i].rdy, tv[i].e, $sformatf("vec%0d", i));

        // lw with three wait cycles in MEM (8 cycles total)
        run_instr(C_LW, 0, 3, h);

        // Reset held mid-MEM of an lw
        enc(C_LW, op, fn);
        mem_wait(P_F, C_LW, 0, op, fn, 1'b1, h);
        simple_phase(P_D, C_LW, op, fn);
        simple_phase(P_E, C_LW, op, fn);
        cyc(1'b1, op, fn, 1'b0, 1'b0, exp_out(P_M, C_LW, 1'b0, 1'b0), "lw mem wait");
        do_reset(3);
        cyc(1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0, f_wait, "fetch after reset");
        run_instr(C_ADDU, 0, 0, h);

        // Timeout in FETCH, then the same with mem_ready on the last allowed cycle
        run_instr(C_ADDU, TO, 0, h);
        if (h) halt_and_reset();
        else begin bad++; total++; $display("FAIL fetch timeout: no halt, wanted halt"); end
        run_instr(C_ADDU, TO - 1, 0, h);
        // Timeout in MEM
        run_instr(C_LW, 0, TO, h);
        if (h) halt_and_reset();

        for (int n = 0; n < 200; n++) begin
            cls_t c = cls_t'($urandom_range(0, 10));
            run_instr(c, pick_wait(), pick_wait(), h);
            if (h) halt_and_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
